stream_output_controller: RTL and testbench
===========================================

// Module: stream_output_controller
// PURPOSE
//  Sequences the output side of the column-stream pipeline: input_buffer -> processing block -> AXI-Stream master.
//  Tracks which processed results are valid image data by delaying the buffer's tags through the pipeline latency.
//  Packs R/G/B results into 32-bit beats and marks the last beat of each frame with tlast.
//  Drives output_has_back_pressure so the input buffer and processing block stall while the output is blocked.
// PARAMETERS
//  DATA_WIDTH          8    bits per colour channel
//  C_AXIS_TDATA_WIDTH  32   master tdata width; fixed at 32
//  BLOCK_SIZE          3    processing window width; first BLOCK_SIZE-1 input columns produce no output
//  IMAGE_HEIGHT        480  rows per column (= input buffer INPUT_HEIGHT)
//  IMAGE_WIDTH         640  input columns per frame; output columns = IMAGE_WIDTH-BLOCK_SIZE+1
//  PIPE_LATENCY        1    data_flowing events from tag sample to matching result at result_*; must be >= 1
// PORTS
//  aclk                        in   1   clock
//  aresetn                     in   1   synchronous, active-low reset
//  data_flowing                in   1   input buffer advanced this cycle
//  is_full_columns_first_input in   1   tag: this flow event starts a full-window column
//  result_R/_G/_B              in   DATA_WIDTH  processing block output pixel
//  output_has_back_pressure    out  1   m_tvalid && !m_tready (combinational)
//  m_tvalid                    out  1   AXIS master valid
//  m_tready                    in   1   AXIS master ready
//  m_tdata                     out  32  {R,G,B,8'h00}
//  m_tstrb                     out  4   constant 4'hF while m_tvalid
//  m_tlast                     out  1   last pixel of frame
//  frame_done                  out  1   one-cycle pulse when the tlast beat is accepted
//  sync_error                  out  1   sticky: tag arrived while CAPTURE was incomplete
// BEHAVIOUR
//  Reset: m_tvalid=0, m_tdata=0, m_tlast=0, frame_done=0, sync_error=0, state=IDLE, counters=0, tag line cleared.
//  Tag delay line: PIPE_LATENCY stages, shifted only when data_flowing=1. Stage 0 loads is_full_columns_first_input.
//   Holds its value during stalls. tag_out = last stage.
//  FSM, evaluated only on data_flowing=1:
//   IDLE: tag_out=1 -> capture current result, row_cnt=1, go to CAPTURE (IMAGE_HEIGHT=1: stay IDLE, column complete).
//   CAPTURE: capture result, row_cnt++. The IMAGE_HEIGHT-th capture -> row_cnt=0, col_cnt++, go to IDLE.
//   CAPTURE with tag_out=1: set sync_error, restart the column (row_cnt=1), keep capturing.
//  Capture: m_tdata<={result_R,result_G,result_B,8'h00}; m_tvalid<=1.
//   m_tlast<=1 iff row = IMAGE_HEIGHT-1 and col = IMAGE_WIDTH-BLOCK_SIZE.
//   On tlast capture, col_cnt wraps to 0.
//  Handshake: m_tvalid falls on m_tvalid&&m_tready unless a capture occurs in the same cycle.
//   Upstream never flows while output_has_back_pressure=1, so the output register never overruns. Single register, no skid buffer.
//  Outputs stay stable while m_tvalid=1 and m_tready=0 (AXIS rule).
//  frame_done=1 for one cycle when m_tvalid&&m_tready&&m_tlast.
//  Non-flow cycles: FSM, counters and tag line hold.
//  Widths: row_cnt $clog2(IMAGE_HEIGHT+1), col_cnt $clog2(IMAGE_WIDTH+1).
//  Reset mid-frame: everything returns to reset values and any pending beat is dropped.
// STRUCTURE
//  Shared package: AXIS byte-lane constants (R=[31:24], G=[23:16], B=[15:8], pad=[7:0]) and the FSM state enum {IDLE, CAPTURE}.
//  Sub-module flow_tag_delay: enable-gated shift register of PIPE_LATENCY x 1 bit, also reused for future sideband tags.
// TESTING (BLOCK_SIZE=3, IMAGE_HEIGHT=4, IMAGE_WIDTH=5, PIPE_LATENCY=1)
//  1. Reset mid-CAPTURE with m_tvalid=1 -> next cycle m_tvalid=0, sync_error=0, state IDLE.
//  2. Tag pulse, then 4 flow events with results R=1..4, m_tready=1 -> 4 beats tdata=32'h01..00..04..00, m_tlast=0.
//  3. 3 full columns streamed -> 12 beats; tlast only on the 12th beat; frame_done pulses once; col_cnt=0 after.
//  4. Hold m_tready=0 for 5 cycles mid-column -> output_has_back_pressure=1 and m_tdata stable.
//     On release, no beat is lost or duplicated.
//  5. Flow events with no tag and state IDLE (padding/partial columns) -> no beats produced.
//  6. Second tag after 2 of 4 rows -> sync_error=1 (sticky); the column restarts and emits 4 more beats.

Source files
------------

// File: rtl/stream_output_controller_pkg.sv
// -----------------------------------------------------------------------------
// stream_output_controller_pkg
//   Shared definitions for the column-stream output controller:
//   - byte-lane positions of a packed RGB beat on the 32-bit AXIS bus
//   - output sequencing FSM state encoding
//   - helper that packs one RGB pixel into a beat
// -----------------------------------------------------------------------------
package stream_output_controller_pkg;

  // Byte lanes of m_tdata: R=[31:24], G=[23:16], B=[15:8], pad=[7:0]
  localparam int unsigned LANE_BITS    = 8;
  localparam int unsigned LANE_R_MSB   = 31;
  localparam int unsigned LANE_G_MSB   = 23;
  localparam int unsigned LANE_B_MSB   = 15;
  localparam int unsigned LANE_PAD_MSB = 7;
  localparam logic [7:0]  PAD_VALUE    = 8'h00;

  typedef enum logic {
    ST_IDLE    = 1'b0,  // waiting for a tagged full-window column
    ST_CAPTURE = 1'b1   // inside a column, capturing one result per flow event
  } state_e;

  function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [31:0] beat;
    beat = '0;
    beat[LANE_R_MSB   -: LANE_BITS] = r;
    beat[LANE_G_MSB   -: LANE_BITS] = g;
    beat[LANE_B_MSB   -: LANE_BITS] = b;
    beat[LANE_PAD_MSB -: LANE_BITS] = PAD_VALUE;
    return beat;
  endfunction

endpackage

// File: rtl/stream_output_controller_flow_tag_delay.sv
// -----------------------------------------------------------------------------
// stream_output_controller_flow_tag_delay
//   Enable-gated shift register, DEPTH stages of WIDTH bits. Used to carry
//   sideband tags alongside the processing pipeline; it advances only when
//   the pipeline advances and holds otherwise.
// Ports:
//   aclk     in   clock
//   aresetn  in   synchronous active-low reset (clears every stage)
//   en_i     in   shift enable (pipeline advanced this cycle)
//   tag_i    in   WIDTH  tag loaded into stage 0
//   tag_o    out  WIDTH  oldest stage
// -----------------------------------------------------------------------------
module stream_output_controller_flow_tag_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  // Stage k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; stage 0 is the newest.
  logic [DEPTH*WIDTH-1:0] chain_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          chain_q <= '0;
        end else if (en_i) begin
          chain_q <= tag_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          chain_q <= '0;
        end else if (en_i) begin
          chain_q <= {chain_q[(DEPTH-1)*WIDTH-1:0], tag_i};
        end
      end
    end
  endgenerate

  assign tag_o = chain_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/stream_output_controller.sv
// -----------------------------------------------------------------------------
// stream_output_controller
//   Output side of the column-stream pipeline. Delays the input buffer's
//   "full column starts" tag by the processing latency, captures each valid
//   result column (IMAGE_HEIGHT pixels) into a single AXIS output register,
//   marks the frame's final pixel with tlast and raises back pressure while
//   the output beat is blocked.
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   data_flowing                  in   input buffer advanced this cycle
//   is_full_columns_first_input   in   tag for this flow event
//   result_R/_G/_B                in   DATA_WIDTH processed pixel
//   output_has_back_pressure      out  m_tvalid && !m_tready
//   m_tvalid/m_tready/m_tdata/m_tstrb/m_tlast   AXIS master
//   frame_done                    out  pulse after the tlast beat is accepted
//   sync_error                    out  sticky: tag seen mid-column
// -----------------------------------------------------------------------------
module stream_output_controller
  import stream_output_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE         = 3,
  parameter int unsigned IMAGE_HEIGHT       = 480,
  parameter int unsigned IMAGE_WIDTH        = 640,
  parameter int unsigned PIPE_LATENCY       = 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            data_flowing,
  input  logic                            is_full_columns_first_input,
  input  logic [DATA_WIDTH-1:0]           result_R,
  input  logic [DATA_WIDTH-1:0]           result_G,
  input  logic [DATA_WIDTH-1:0]           result_B,
  output logic                            output_has_back_pressure,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_tstrb,
  output logic                            m_tlast,
  output logic                            frame_done,
  output logic                            sync_error
);

  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT + 1);
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - BLOCK_SIZE);

  state_e                          state_q, state_d;
  logic [ROW_W-1:0]                row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]                col_cnt_q, col_cnt_d;
  logic                            tvalid_q, tvalid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                            tlast_q, tlast_d;
  logic                            frame_done_q, frame_done_d;
  logic                            sync_error_q, sync_error_d;

  logic                            tag_out;
  logic                            capture;
  logic [ROW_W-1:0]                row_idx;

  stream_output_controller_flow_tag_delay #(
    .DEPTH (PIPE_LATENCY),
    .WIDTH (1)
  ) u_tag_delay (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en_i    (data_flowing),
    .tag_i   (is_full_columns_first_input),
    .tag_o   (tag_out)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= '0;
      col_cnt_q    <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    sync_error_d = sync_error_q;
    capture      = 1'b0;
    row_idx      = '0;

    frame_done_d = tvalid_q && m_tready && tlast_q;
    if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end

    // row_idx is the row position of the pixel captured on this flow event.
    if (data_flowing) begin
      unique case (state_q)
        ST_IDLE: begin
          if (tag_out) begin
            capture = 1'b1;
          end
        end
        ST_CAPTURE: begin
          capture = 1'b1;
          if (tag_out) begin
            // A new column started before this one completed: restart.
            sync_error_d = 1'b1;
          end else begin
            row_idx = row_cnt_q;
          end
        end
        default: ;
      endcase
    end

    // Upstream never flows under back pressure, so a capture always lands
    // in an empty (or just-accepted) output register.
    if (capture) begin
      tvalid_d = 1'b1;
      tdata_d  = pack_pixel(result_R, result_G, result_B);
      tlast_d  = (row_idx == LAST_ROW) && (col_cnt_q == LAST_COL);
      if (row_idx == LAST_ROW) begin
        state_d   = ST_IDLE;
        row_cnt_d = '0;
        col_cnt_d = tlast_d ? '0 : col_cnt_q + COL_W'(1);
      end else begin
        state_d   = ST_CAPTURE;
        row_cnt_d = row_idx + ROW_W'(1);
      end
    end
  end

  assign output_has_back_pressure = tvalid_q && !m_tready;
  assign m_tvalid   = tvalid_q;
  assign m_tdata    = tdata_q;
  assign m_tstrb    = '1;
  assign m_tlast    = tlast_q;
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_stream_output_controller.sv
// -----------------------------------------------------------------------------
// tb_stream_output_controller
//   Directed scenarios plus a randomized phase. A queue-based model of the
//   expected beat stream is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_stream_output_controller;

  localparam int H = 4;
  localparam int W = 5;
  localparam int B = 3;
  localparam int L = 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        data_flowing = 1'b0;
  logic        tag_in = 1'b0;
  logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        m_tready = 1'b0;
  logic        output_has_back_pressure;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        frame_done;
  logic        sync_error;

  stream_output_controller #(
    .DATA_WIDTH(8), .C_AXIS_TDATA_WIDTH(32), .BLOCK_SIZE(B),
    .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .PIPE_LATENCY(L)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .data_flowing(data_flowing),
    .is_full_columns_first_input(tag_in),
    .result_R(r_in), .result_G(g_in), .result_B(b_in),
    .output_has_back_pressure(output_has_back_pressure),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast),
    .frame_done(frame_done), .sync_error(sync_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] data; bit last; } beat_t;

  // Model: beats produced but not yet accepted, tags awaiting their result,
  // and the position inside the frame of the next pixel.
  beat_t exp_beats[$];
  bit    m_tags[$];
  bit    m_in_col;
  int    m_row, m_col;
  bit    m_sync, m_fd;

  // Observed accepted beats and frame_done pulses.
  logic [31:0] seen_data[$];
  bit          seen_last[$];
  int          fd_count = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_beats.delete();
    m_tags.delete();
    for (int i = 0; i < L; i++) m_tags.push_back(1'b0);
    m_in_col = 0; m_row = 0; m_col = 0; m_sync = 0; m_fd = 0;
  endfunction

  // Advance the model across one clock edge with the given inputs.
  function automatic void model_step(bit rst_n, bit flow, bit tag,
                                     logic [7:0] r, logic [7:0] g, logic [7:0] b,
                                     bit ready);
    bit acc, tag_out;
    int row;
    beat_t nb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc  = (exp_beats.size() > 0) && ready;
    m_fd = acc && exp_beats[0].last;
    if (acc) void'(exp_beats.pop_front());
    if (flow) begin
      tag_out = m_tags.pop_front();
      m_tags.push_back(tag);
      if (tag_out && m_in_col) m_sync = 1;
      if (tag_out || m_in_col) begin
        row     = tag_out ? 0 : m_row;
        nb.data = {r, g, b, 8'h00};
        nb.last = (row == H - 1) && (m_col == W - B);
        exp_beats.push_back(nb);
        if (row == H - 1) begin
          m_in_col = 0;
          m_row    = 0;
          m_col    = nb.last ? 0 : m_col + 1;
        end else begin
          m_in_col = 1;
          m_row    = row + 1;
        end
      end
    end
  endfunction

  task automatic compare();
    bit ev;
    ev = exp_beats.size() > 0;
    chk("m_tvalid", m_tvalid, ev);
    if (ev) begin
      chk("m_tdata", m_tdata, exp_beats[0].data);
      chk("m_tlast", m_tlast, exp_beats[0].last);
      chk("m_tstrb", m_tstrb, 4'hF);
    end
    chk("back_pressure", output_has_back_pressure, ev && !m_tready);
    chk("frame_done", frame_done, m_fd);
    chk("sync_error", sync_error, m_sync);
    chk("model_overrun", exp_beats.size() > 1, 0);
    if (frame_done === 1'b1) fd_count++;
  endtask

  // One clock cycle: check, drive inputs (flow gated by back pressure), model.
  task automatic cycle(bit rst_n, bit want_flow, bit tag,
                       logic [7:0] r, logic [7:0] g, logic [7:0] b, bit ready);
    bit flow;
    @(negedge aclk);
    compare();
    flow = rst_n && want_flow && !((exp_beats.size() > 0) && !ready);
    aresetn = rst_n; m_tready = ready; tag_in = tag;
    r_in = r; g_in = g; b_in = b; data_flowing = flow;
    if (rst_n && m_tvalid && ready) begin
      seen_data.push_back(m_tdata);
      seen_last.push_back(m_tlast);
    end
    model_step(rst_n, flow, tag, r, g, b, ready);
  endtask

  task automatic flow1(bit tag, logic [7:0] r);
    cycle(1, 1, tag, r, 8'h00, 8'h00, 1);
  endtask

  task automatic idle(int n, bit ready);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, ready);
  endtask

  task automatic after_edge();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int base, fd_base, nlast, since_tag;
    bit tg;
    model_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tdata", m_tdata, 32'h0);
    chk("reset_tlast", m_tlast, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_sync_error", sync_error, 0);

    // 1. Reset mid-CAPTURE with a pending beat and sync_error set.
    cycle(1, 0, 0, 0, 0, 0, 1);
    flow1(1, 8'hA0);
    flow1(0, 8'hA1);
    flow1(1, 8'hA2);
    flow1(0, 8'hA3);
    after_edge();
    chk("pre_reset_tvalid", m_tvalid, 1);
    chk("pre_reset_sync", sync_error, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("mid_reset_tvalid", m_tvalid, 0);
    chk("mid_reset_sync", sync_error, 0);
    chk("mid_reset_tlast", m_tlast, 0);
    flow1(0, 8'h55);
    flow1(0, 8'h56);
    after_edge();
    chk("post_reset_idle_tvalid", m_tvalid, 0);

    // 2/3. Three full columns: R = 1..12, tlast only on the 12th beat.
    base = seen_data.size();
    fd_base = fd_count;
    for (int c = 0; c < 3; c++) begin
      flow1(1, 8'hEE);
      for (int r = 0; r < H; r++) flow1(0, 8'(c * H + r + 1));
    end
    idle(3, 1);
    chk("col0_beat0", seen_data[base], 32'h0100_0000);
    chk("col0_beat3", seen_data[base + 3], 32'h0400_0000);
    chk("frame_beats", seen_data.size() - base, 12);
    chk("frame_last_on_12th", seen_last[base + 11], 1);
    nlast = 0;
    for (int i = base; i < seen_last.size(); i++) nlast += seen_last[i];
    chk("frame_tlast_count", nlast, 1);
    chk("frame_done_pulses", fd_count - fd_base, 1);

    // 4. Back pressure for 5 cycles mid-column.
    base = seen_data.size();
    flow1(1, 8'hEE);
    flow1(0, 8'h21);
    flow1(0, 8'h22);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 8'h99, 8'h99, 8'h99, 0);
      after_edge();
      chk("bp_asserted", output_has_back_pressure, 1);
      chk("bp_tdata_held", m_tdata, 32'h2200_0000);
    end
    flow1(0, 8'h23);
    flow1(0, 8'h24);
    idle(2, 1);
    chk("bp_column_beats", seen_data.size() - base, 4);
    chk("bp_last_beat", seen_data[base + 3], 32'h2400_0000);

    // 5. Untagged flow events in IDLE produce nothing.
    base = seen_data.size();
    for (int i = 0; i < 6; i++) flow1(0, 8'(8'h30 + i));
    after_edge();
    chk("untagged_tvalid", m_tvalid, 0);
    chk("untagged_beats", seen_data.size() - base, 0);

    // 6. Second tag after 2 of 4 rows.
    base = seen_data.size();
    flow1(1, 8'hEE);
    flow1(0, 8'h41);
    flow1(1, 8'h42);
    flow1(0, 8'h50);
    flow1(0, 8'h51);
    flow1(0, 8'h52);
    flow1(0, 8'h53);
    idle(3, 1);
    chk("sync_sticky", sync_error, 1);
    chk("sync_beats", seen_data.size() - base, 6);
    chk("sync_restart_row0", seen_data[base + 2], 32'h5000_0000);

    // Randomized phase.
    since_tag = 0;
    for (int i = 0; i < 4000; i++) begin
      tg = ((since_tag >= H + 1) && ($urandom_range(0, 2) == 0)) ||
           ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 299) == 0) begin
        cycle(0, 0, 0, 0, 0, 0, $urandom_range(0, 1));
        since_tag = 0;
      end else begin
        cycle(1, $urandom_range(0, 3) != 0, tg, 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 9) < 7);
        if (data_flowing) since_tag = tg ? 0 : since_tag + 1;
      end
    end
    idle(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
